// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration loader and its strobe decoder.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } cfg_state_e;

  // Field codes: order in which a block's config registers are written.
  localparam logic [1:0] FLD_X  = 2'd0;
  localparam logic [1:0] FLD_Y  = 2'd1;
  localparam logic [1:0] FLD_AB = 2'd2;
  localparam logic [1:0] FLD_CX = 2'd3;

  localparam int CFG_BYTES_PER_BLOCK = 4;

endpackage

// File: rtl/cfg_strobe_decode.sv
// Registered decoder: turns an accepted (block, field) pair into a single
// one-cycle strobe bit on one of the four per-block write-enable vectors.
module cfg_strobe_decode
  import cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic [BLK_W-1:0]      blk_idx,
  input  logic [1:0]            fld_idx,
  output logic [NUM_BLOCKS-1:0] set_x,
  output logic [NUM_BLOCKS-1:0] set_y,
  output logic [NUM_BLOCKS-1:0] set_ab,
  output logic [NUM_BLOCKS-1:0] set_cx
);

  logic [NUM_BLOCKS-1:0] blk_onehot;

  // One-hot position of the block currently being written.
  always_comb begin
    blk_onehot = NUM_BLOCKS'(1) << blk_idx;
  end

  // Strobes default low every cycle; reset drops any strobe in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_x  <= '0;
      set_y  <= '0;
      set_ab <= '0;
      set_cx <= '0;
    end else begin
      set_x  <= '0;
      set_y  <= '0;
      set_ab <= '0;
      set_cx <= '0;
      if (accept) begin
        case (fld_idx)
          FLD_X:   set_x  <= blk_onehot;
          FLD_Y:   set_y  <= blk_onehot;
          FLD_AB:  set_ab <= blk_onehot;
          default: set_cx <= blk_onehot;
        endcase
      end
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Configuration sequencer: accepts a byte stream and writes each byte into the
// next block/field of the fabric, holding the fabric disabled until the whole
// array has been loaded.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            cfg_in,
  output logic [NUM_BLOCKS-1:0] set_x,
  output logic [NUM_BLOCKS-1:0] set_y,
  output logic [NUM_BLOCKS-1:0] set_ab,
  output logic [NUM_BLOCKS-1:0] set_cx,
  output logic                  busy,
  output logic                  done,
  output logic                  fabric_en
);

  cfg_state_e       state;
  logic [BLK_W-1:0] blk_idx;
  logic [1:0]       fld_idx;
  logic             accept;
  logic             last_byte;

  // abort gates in_ready so a byte presented in the abort cycle is never taken.
  assign in_ready  = (state == LOAD) && !abort;
  assign accept    = in_valid && in_ready;
  assign last_byte = (blk_idx == BLK_W'(NUM_BLOCKS - 1)) && (fld_idx == FLD_CX);

  // Load FSM with block/field counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk_idx   <= '0;
      fld_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fabric_en <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            blk_idx   <= '0;
            fld_idx   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fabric_en <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            blk_idx <= '0;
            fld_idx <= '0;
            busy    <= 1'b0;
          end else if (accept) begin
            if (last_byte) begin
              state     <= DONE;
              blk_idx   <= '0;
              fld_idx   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              fabric_en <= 1'b1;
            end else begin
              fld_idx <= fld_idx + 2'd1;
              if (fld_idx == FLD_CX) begin
                blk_idx <= blk_idx + BLK_W'(1);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Config byte register; holds its value between accepted bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_in <= 8'h00;
    end else if (accept) begin
      cfg_in <= in_data;
    end
  end

  cfg_strobe_decode #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .BLK_W      (BLK_W)
  ) u_strobe_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .blk_idx (blk_idx),
    .fld_idx (fld_idx),
    .set_x   (set_x),
    .set_y   (set_y),
    .set_ab  (set_ab),
    .set_cx  (set_cx)
  );

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration sequencer for the LUT fabric.
- Accepts a byte stream over a valid/ready handshake and distributes each byte to the fabric's per-block config bus as a one-cycle write strobe. Each block has four config registers, written in the order x, y, ab, cx.
- Holds the fabric disabled while loading, then releases it once every block is configured.
- Sits between the chip's config input pins and the array of logic blocks.

Parameters:
- NUM_BLOCKS, 8, number of logic blocks in the fabric; must be >= 1.
- BLK_W, $clog2(NUM_BLOCKS) with a minimum of 1, width of the block index counter.

Ports:
- clk  input  1  fabric clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a full configuration load
- abort  input  1  single-cycle pulse; cancels a load in progress
- in_data  input  8  configuration byte
- in_valid  input  1  in_data holds a valid byte
- in_ready  output  1  loader will accept in_data this cycle
- cfg_in  output  8  config byte, shared by all blocks
- set_x  output  NUM_BLOCKS  one-hot write strobe for each block's x register
- set_y  output  NUM_BLOCKS  one-hot write strobe for each block's y register
- set_ab  output  NUM_BLOCKS  one-hot write strobe for each block's ab register
- set_cx  output  NUM_BLOCKS  one-hot write strobe for each block's cx register
- busy  output  1  a load is in progress
- done  output  1  the last load completed; fabric is configured
- fabric_en  output  1  fabric run enable (drives the blocks' rst_n qualifier)

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, counters=0, cfg_in=0. All strobes, in_ready, busy, done and fabric_en are 0. Any strobe in flight is dropped immediately.
- State machine: IDLE, LOAD, DONE.
  - IDLE: start goes to LOAD, clearing blk_idx, fld_idx, done and fabric_en.
  - LOAD: in_ready=1 and busy=1. A byte is accepted when in_valid and in_ready are both 1.
  - DONE: done=1 and fabric_en=1. start re-enters LOAD; done and fabric_en drop the cycle after start.
- Accepting a byte:
  - cfg_in is registered from in_data.
  - Exactly one strobe bit is asserted for exactly one cycle, in the cycle after acceptance (latency 1). The bit is the field selected by fld_idx (0=x, 1=y, 2=ab, 3=cx), at block position blk_idx.
  - cfg_in holds its last value when no strobe is asserted.
- Counters:
  - fld_idx is 2 bits and wraps 3 to 0. On that wrap, blk_idx increments.
  - Acceptance at blk_idx=NUM_BLOCKS-1 with fld_idx=3 moves the state to DONE the next cycle. That final strobe coincides with the transition into DONE.
  - A full load is exactly 4*NUM_BLOCKS accepted bytes.
- in_valid=0 during LOAD: a stall. Counters hold and no strobe is issued; there is no timeout.
- Strobe invariants:
  - At most one bit across all four strobe vectors is high in any cycle.
  - No strobe outside a cycle that follows an acceptance.
- abort:
  - In LOAD: go to IDLE next cycle. Counters are cleared, fabric_en and done stay 0, and any byte presented that same cycle is not accepted (in_ready is gated by abort).
  - In IDLE or DONE: ignored.
- start:
  - During LOAD: ignored.
  - Together with abort in LOAD: abort wins.
  - Together with abort in IDLE or DONE: start wins.
- Blocks that were already written keep their values after an abort. The fabric remains disabled until a complete load finishes.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum {IDLE, LOAD, DONE};
  - field codes FLD_X=0, FLD_Y=1, FLD_AB=2, FLD_CX=3;
  - constant CFG_BYTES_PER_BLOCK=4.
- One sub-module, cfg_strobe_decode: a registered decoder from (accept, blk_idx, fld_idx) to the four one-hot strobe vectors. This keeps the FSM and counters separate from the NUM_BLOCKS-wide fan-out.

Test Plan:
- Reset, then start, then 32 bytes 0x00..0x1F with in_valid held high (NUM_BLOCKS=8):
  - strobes appear one cycle after each acceptance;
  - byte 0x05 gives set_y[1] with cfg_in=0x05;
  - byte 0x1F gives set_cx[7];
  - done=1 and fabric_en=1 on the cycle after the last acceptance; busy=0.
- Same load with in_valid toggled every other cycle: the strobe sequence and values are identical, with no strobe on stall cycles, and done is reached after 32 acceptances.
- abort after byte 9: in_ready=0 in the abort cycle, state returns to IDLE, fabric_en stays 0. A subsequent start followed by 32 bytes starts again at set_x[0].
- start while in DONE: fabric_en falls the next cycle and busy=1. Reload 32 bytes: fabric_en returns to 1.
- rst_n asserted mid-load, between an acceptance and its strobe cycle: all outputs are 0 immediately, no strobe is emitted, and the loader is in IDLE after release.
- Every cycle, assert that popcount over {set_x, set_y, set_ab, set_cx} is <= 1 and that busy and done are never both 1.
